// File: rtl/ecc_pkg.sv
// Shared types and default sizes for the ECC scalar-multiplication sequencer.
package ecc_pkg;

    localparam int N_DEF = 231;
    localparam int K_DEF = 231;

    typedef enum logic [2:0] {
        IDLE,
        BIT,
        DBL_WAIT,
        ADDSEL,
        ADD_WAIT,
        NEXT,
        DONE
    } state_t;

    typedef struct packed {
        logic [N_DEF-1:0] x;
        logic [N_DEF-1:0] y;
        logic             inf;
    } point_t;

endpackage

// File: rtl/ecc_point_classify.sv
// Relates accumulator Q to base point P: infinity, identical, or same x (Q = -P).
module ecc_point_classify
    import ecc_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] qx,
    input  logic [N-1:0] qy,
    input  logic         q_inf,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    output logic         is_inf,
    output logic         equal,
    output logic         negated
);

    logic x_eq;
    logic y_eq;

    assign x_eq    = (qx == px);
    assign y_eq    = (qy == py);
    // On the curve a shared x with differing y can only be the negation of P.
    assign is_inf  = q_inf;
    assign equal   = !q_inf && x_eq && y_eq;
    assign negated = !q_inf && x_eq && !y_eq;

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving external point-double/point-add units.
module ecc_scalar_mult_ctrl
    import ecc_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] k,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] qx,
    output logic [N-1:0] qy,
    output logic         q_inf,
    output logic         dbl_start,
    output logic [N-1:0] dbl_x,
    output logic [N-1:0] dbl_y,
    input  logic         dbl_done,
    input  logic [N-1:0] dbl_x3,
    input  logic [N-1:0] dbl_y3,
    input  logic         dbl_inf,
    output logic         add_start,
    output logic [N-1:0] add_x1,
    output logic [N-1:0] add_y1,
    output logic [N-1:0] add_x2,
    output logic [N-1:0] add_y2,
    input  logic         add_done,
    input  logic [N-1:0] add_x3,
    input  logic [N-1:0] add_y3,
    input  logic         add_inf
);

    localparam int            IW      = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(K - 1);

    state_t        state, state_n;
    logic [IW-1:0] idx;
    logic [K-1:0]  k_r;
    logic [N-1:0]  px_r, py_r;
    logic [N-1:0]  acc_x, acc_y;
    logic          acc_inf;
    logic          redirect;
    logic          is_inf, equal, negated;

    logic accept, issue_dbl_q, issue_dbl_p, issue_add;
    logic cap_dbl, cap_add, load_p, clear_q, dec_idx, finish;

    ecc_point_classify #(.N(N)) u_classify (
        .qx      (acc_x),
        .qy      (acc_y),
        .q_inf   (acc_inf),
        .px      (px_r),
        .py      (py_r),
        .is_inf  (is_inf),
        .equal   (equal),
        .negated (negated)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        issue_dbl_q = 1'b0;
        issue_dbl_p = 1'b0;
        issue_add   = 1'b0;
        cap_dbl     = 1'b0;
        cap_add     = 1'b0;
        load_p      = 1'b0;
        clear_q     = 1'b0;
        dec_idx     = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = BIT;
                end
            end
            BIT: begin
                if (is_inf) begin
                    state_n = ADDSEL;
                end else begin
                    issue_dbl_q = 1'b1;
                    state_n     = DBL_WAIT;
                end
            end
            DBL_WAIT: begin
                if (dbl_done) begin
                    cap_dbl = 1'b1;
                    state_n = redirect ? NEXT : ADDSEL;
                end
            end
            ADDSEL: begin
                if (!k_r[idx]) begin
                    state_n = NEXT;
                end else if (is_inf) begin
                    load_p  = 1'b1;
                    state_n = NEXT;
                end else if (equal) begin
                    // Q + P with Q == P is a doubling; the adder never sees equal operands.
                    issue_dbl_p = 1'b1;
                    state_n     = DBL_WAIT;
                end else if (negated) begin
                    clear_q = 1'b1;
                    state_n = NEXT;
                end else begin
                    issue_add = 1'b1;
                    state_n   = ADD_WAIT;
                end
            end
            ADD_WAIT: begin
                if (add_done) begin
                    cap_add = 1'b1;
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (idx == '0) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end else begin
                    dec_idx = 1'b1;
                    state_n = BIT;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= IDX_TOP;
            acc_inf   <= 1'b1;
            redirect  <= 1'b0;
            dbl_start <= 1'b0;
            add_start <= 1'b0;
            dbl_x     <= '0;
            dbl_y     <= '0;
            add_x1    <= '0;
            add_y1    <= '0;
            add_x2    <= '0;
            add_y2    <= '0;
            qx        <= '0;
            qy        <= '0;
            q_inf     <= 1'b1;
        end else begin
            state     <= state_n;
            dbl_start <= issue_dbl_q | issue_dbl_p;
            add_start <= issue_add;
            if (accept) begin
                idx      <= IDX_TOP;
                acc_inf  <= 1'b1;
                redirect <= 1'b0;
            end
            if (dec_idx) idx <= idx - 1'b1;
            if (issue_dbl_q) begin
                dbl_x <= acc_x;
                dbl_y <= acc_y;
            end
            if (issue_dbl_p) begin
                dbl_x    <= px_r;
                dbl_y    <= py_r;
                redirect <= 1'b1;
            end
            if (issue_add) begin
                add_x1 <= acc_x;
                add_y1 <= acc_y;
                add_x2 <= px_r;
                add_y2 <= py_r;
            end
            if (cap_dbl) begin
                acc_inf  <= dbl_inf;
                redirect <= 1'b0;
            end
            if (cap_add) acc_inf <= add_inf;
            if (load_p)  acc_inf <= 1'b0;
            if (clear_q) acc_inf <= 1'b1;
            if (finish) begin
                qx    <= acc_inf ? '0 : acc_x;
                qy    <= acc_inf ? '0 : acc_y;
                q_inf <= acc_inf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            k_r  <= k;
            px_r <= px;
            py_r <= py;
        end
        if (cap_dbl) begin
            acc_x <= dbl_x3;
            acc_y <= dbl_y3;
        end
        if (cap_add) begin
            acc_x <= add_x3;
            acc_y <= add_y3;
        end
        if (load_p) begin
            acc_x <= px_r;
            acc_y <= py_r;
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Scoreboard bench: y^2 = x^3 + 2x + 2 mod 17, P = (5,1), with latency-randomised unit models.
module tb_ecc_scalar_mult_ctrl;

    localparam int N = 8;
    localparam int K = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [K-1:0] k;
    logic [N-1:0] px, py;
    logic         busy, done, q_inf;
    logic [N-1:0] qx, qy;
    logic         dbl_start, dbl_done, dbl_inf;
    logic [N-1:0] dbl_x, dbl_y, dbl_x3, dbl_y3;
    logic         add_start, add_done, add_inf;
    logic [N-1:0] add_x1, add_y1, add_x2, add_y2, add_x3, add_y3;

    typedef struct {
        int x;
        int y;
        int inf;
        int nd;
        int na;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   start_cyc  = 0;
    int   dones      = 0;
    int   n_dbl      = 0;
    int   n_add      = 0;
    bit   spurious   = 1'b0;

    ecc_scalar_mult_ctrl #(.N(N), .K(K)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k         (k),
        .px        (px),
        .py        (py),
        .busy      (busy),
        .done      (done),
        .qx        (qx),
        .qy        (qy),
        .q_inf     (q_inf),
        .dbl_start (dbl_start),
        .dbl_x     (dbl_x),
        .dbl_y     (dbl_y),
        .dbl_done  (dbl_done),
        .dbl_x3    (dbl_x3),
        .dbl_y3    (dbl_y3),
        .dbl_inf   (dbl_inf),
        .add_start (add_start),
        .add_x1    (add_x1),
        .add_y1    (add_y1),
        .add_x2    (add_x2),
        .add_y2    (add_y2),
        .add_done  (add_done),
        .add_x3    (add_x3),
        .add_y3    (add_y3),
        .add_inf   (add_inf)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int md(input int a);
        return ((a % 17) + 17) % 17;
    endfunction

    function automatic int inv(input int a);
        for (int b = 1; b < 17; b++) if (md(a * b) == 1) return b;
        return 0;
    endfunction

    task automatic ec_dbl(input int x, input int y, output int x3, output int y3, output bit inf);
        int l;
        if (y == 0) begin
            x3 = 0; y3 = 0; inf = 1'b1;
            return;
        end
        l   = md((3 * x * x + 2) * inv(md(2 * y)));
        x3  = md(l * l - 2 * x);
        y3  = md(l * (x - x3) - y);
        inf = 1'b0;
    endtask

    task automatic ec_add(input int x1, input int y1, input int x2, input int y2,
                          output int x3, output int y3, output bit inf);
        int l;
        if (x1 == x2) begin
            if (y1 == y2) ec_dbl(x1, y1, x3, y3, inf);
            else begin
                x3 = 0; y3 = 0; inf = 1'b1;
            end
            return;
        end
        l   = md(md(y2 - y1) * inv(md(x2 - x1)));
        x3  = md(l * l - x1 - x2);
        y3  = md(l * (x1 - x3) - y1);
        inf = 1'b0;
    endtask

    // Doubling unit model; in spurious mode it raises garbage dbl_done whenever idle.
    initial begin
        int cnt;
        int rx, ry;
        bit rinf;
        logic [N-1:0] ox, oy;
        cnt = 0;
        dbl_done = 1'b0; dbl_x3 = '0; dbl_y3 = '0; dbl_inf = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dbl_done = 1'b0;
            if (reset) begin
                cnt   = 0;
                n_dbl = 0;
            end else if (cnt > 0) begin
                chk("dbl_operand_stable", int'({dbl_x, dbl_y}), int'({ox, oy}));
                chk("dbl_overlap", int'(dbl_start | add_start), 0);
                cnt--;
                if (cnt == 0) begin
                    dbl_done = 1'b1;
                    dbl_x3 = N'(rx); dbl_y3 = N'(ry); dbl_inf = rinf;
                end
            end else if (dbl_start) begin
                n_dbl++;
                ox = dbl_x; oy = dbl_y;
                ec_dbl(int'(ox), int'(oy), rx, ry, rinf);
                cnt = $urandom_range(1, 5);
            end else if (spurious) begin
                dbl_done = 1'b1;
                dbl_x3 = '0; dbl_y3 = '0; dbl_inf = 1'b1;
            end
        end
    end

    // Addition unit model.
    initial begin
        int cnt;
        int rx, ry;
        bit rinf;
        logic [4*N-1:0] ops;
        cnt = 0;
        add_done = 1'b0; add_x3 = '0; add_y3 = '0; add_inf = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            add_done = 1'b0;
            if (reset) begin
                cnt   = 0;
                n_add = 0;
            end else if (cnt > 0) begin
                chk("add_operand_stable", int'({add_x1, add_y1, add_x2, add_y2}), int'(ops));
                chk("add_overlap", int'(dbl_start | add_start), 0);
                cnt--;
                if (cnt == 0) begin
                    add_done = 1'b1;
                    add_x3 = N'(rx); add_y3 = N'(ry); add_inf = rinf;
                end
            end else if (add_start) begin
                n_add++;
                ops = {add_x1, add_y1, add_x2, add_y2};
                ec_add(int'(add_x1), int'(add_y1), int'(add_x2), int'(add_y2), rx, ry, rinf);
                cnt = $urandom_range(1, 5);
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("qx", int'(qx), e.x);
                    chk("qy", int'(qy), e.y);
                    chk("q_inf", int'(q_inf), e.inf);
                    chk("dbl_start_count", n_dbl, e.nd);
                    chk("add_start_count", n_add, e.na);
                    if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
                end
                n_dbl = 0;
                n_add = 0;
            end
        end
    end

    task automatic run(input logic [K-1:0] kk, input int ex, input int ey, input int einf,
                       input int nd, input int na, input int lat, input bit poke);
        exp_t e;
        int   target;
        e.x = ex; e.y = ey; e.inf = einf; e.nd = nd; e.na = na; e.lat = lat;
        sb.push_back(e);
        target    = dones + 1;
        k         = kk;
        px        = 8'd5;
        py        = 8'd1;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (4) @(negedge clk);
            k = 8'hFF; px = 8'd3; py = 8'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && dones < target; i++) @(negedge clk);
        if (dones < target) chk("done_timeout", dones, target);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        k     = '0;
        px    = '0;
        py    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q_inf", int'(q_inf), 1);
        chk("rst_qxy", int'({qx, qy}), 0);
        chk("rst_unit_starts", int'({dbl_start, add_start}), 0);
        chk("rst_operands", int'({dbl_x, dbl_y, add_x1, add_y1}), 0);

        run(8'd0,  0,  0,  1, 0, 0, 3 * K + 1, 1'b0);
        run(8'd2,  6,  3,  0, 1, 0, -1, 1'b0);
        run(8'd3,  10, 6,  0, 1, 1, -1, 1'b0);
        run(8'd10, 7,  11, 0, 3, 1, -1, 1'b1);
        run(8'd18, 5,  16, 0, 4, 1, -1, 1'b0);
        run(8'd19, 0,  0,  1, 4, 1, -1, 1'b0);
        run(8'd21, 6,  3,  0, 5, 1, -1, 1'b0);
        spurious = 1'b1;
        run(8'd3,  10, 6,  0, 1, 1, -1, 1'b0);
        spurious = 1'b0;

        // Abort a run while the doubler is busy.
        k = 8'd10; px = 8'd5; py = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !dbl_start; i++) @(negedge clk);
        chk("abort_dbl_start_seen", int'(dbl_start), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q_inf", int'(q_inf), 1);
        chk("abort_qxy", int'({qx, qy}), 0);
        chk("abort_dbl_start", int'(dbl_start), 0);
        repeat (30) @(negedge clk);

        run(8'd3, 10, 6, 0, 1, 1, -1, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
- Left-to-right double-and-add sequencer that computes Q = k·P on a short Weierstrass curve mod p.
- Acts as the initiator for the point-arithmetic units: it issues requests to an external point-doubling unit and an external point-addition unit through start/done handshakes, and consumes their results.
- Owns the accumulator, point-at-infinity tracking and the special cases (Q = ∞, Q = P, Q = −P), so the arithmetic units only ever see well-formed operands.

Parameters:
N, 231, coordinate width in bits (x, y, all unit operands and results)
K, 231, scalar width in bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
k  in  K  scalar; latched on accepted start
px  in  N  base point x; latched on accepted start
py  in  N  base point y; latched on accepted start
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle pulse; qx/qy/q_inf valid in this cycle
qx  out  N  result x; holds until next accepted start
qy  out  N  result y; holds until next accepted start
q_inf  out  1  result is the point at infinity
dbl_start  out  1  one-cycle request pulse to the doubling unit
dbl_x  out  N  doubling operand x; stable from dbl_start until dbl_done
dbl_y  out  N  doubling operand y; stable from dbl_start until dbl_done
dbl_done  in  1  doubling result valid
dbl_x3  in  N  doubling result x
dbl_y3  in  N  doubling result y
dbl_inf  in  1  doubling result is ∞
add_start  out  1  one-cycle request pulse to the addition unit
add_x1  out  N  addition operand 1 x; stable until add_done
add_y1  out  N  addition operand 1 y; stable until add_done
add_x2  out  N  addition operand 2 x; stable until add_done
add_y2  out  N  addition operand 2 y; stable until add_done
add_done  in  1  addition result valid
add_x3  in  N  addition result x
add_y3  in  N  addition result y
add_inf  in  1  addition result is ∞

Behaviour:
- Reset values:
  - All outputs are 0.
  - q_inf is 1.
  - State is IDLE.
  - Bit index is K−1.
- Accepted start: start=1 while in IDLE latches k, px, py, sets the accumulator to Q=∞ and idx=K−1, and moves to BIT. start is ignored in every other state.
- BIT:
  - If Q=∞, doubling is skipped; go to ADDSEL.
  - Otherwise drive dbl_x/dbl_y=Q, pulse dbl_start, and go to DBL_WAIT.
- DBL_WAIT:
  - On dbl_done, capture Q=(dbl_x3, dbl_y3) and q_inf=dbl_inf.
  - Then go to ADDSEL, or to NEXT if this was a redirected add.
- ADDSEL, evaluated in priority order:
  1. k[idx]=0: go to NEXT.
  2. Q=∞: Q=P, q_inf=0, go to NEXT.
  3. Qx==Px and Qy==Py: redirect to the doubler with operand P (pulse dbl_start) and go to DBL_WAIT with the redirect flag set.
  4. Qx==Px only: q_inf=1, go to NEXT.
  5. Otherwise: drive add operands (Q, P), pulse add_start, and go to ADD_WAIT.
- ADD_WAIT: on add_done, capture Q and q_inf from add_x3/add_y3/add_inf, then go to NEXT.
- NEXT: if idx==0 go to DONE; otherwise decrement idx and go to BIT.
- DONE:
  - done=1 for exactly one cycle.
  - qx/qy/q_inf reflect Q.
  - qx/qy are forced to 0 when q_inf=1.
  - Return to IDLE.
- Latency: a bit costs 3 cycles plus the unit wait cycles. When no unit request is issued (e.g. k=0), done is high exactly 3K+1 cycles after the start-sampling cycle.
- dbl_done/add_done arriving outside the matching WAIT state are ignored.
- At most one unit request is outstanding at any time.
- Reset mid-operation:
  - Immediate return to IDLE with reset values.
  - No done pulse is generated.
  - External units share the same reset.

Decomposition:
- Shared package ecc_pkg holds:
  - the FSM state enum (IDLE, BIT, DBL_WAIT, ADDSEL, ADD_WAIT, NEXT, DONE);
  - the point struct (x, y, inf);
  - the default N/K constants.
- A single sub-module ecc_point_classify (purely combinational) is natural: Q, P, q_inf → {is_inf, equal, negated}.
- Everything else stays in one FSM module.

Test Plan:
Bench setup: N=8, K=8; curve y²=x³+2x+2 mod 17; P=(5,1), order 19; behavioural dbl/add models with random 1–5 cycle latency.
- k=0 → done at exactly cycle 25 after start, q_inf=1, qx=qy=0, no dbl_start/add_start pulses.
- k=2 → (6,3), q_inf=0; exactly one dbl_start, zero add_start. k=3 → (10,6).
- k=10 → (7,11); k=18 → (5,16), i.e. −P.
- k=19 → q_inf=1 via the Qx==Px, Qy≠Py branch, with no add_start on the final bit. k=21 → (6,3) via the Q==P redirect to the doubler.
- Corner-case pulses and protocol checks:
  - start pulsed while busy → ignored; the running result is unaffected.
  - Spurious dbl_done in ADDSEL → ignored.
  - Assertion: operands stay stable until done.
- Reset asserted during DBL_WAIT → next cycle in IDLE, busy=0, q_inf=1, no done. A following k=3 run → (10,6).
